sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
- Upstream command stage for the team's SR flip-flop (ports clk, s, r, q, qbar).
- Takes two raw, possibly bouncy, asynchronous request lines (set_in, clr_in) and synchronises and debounces each.
- Converts each debounced rising edge into a single-cycle s or r pulse.
- Guarantees the downstream flip-flop never sees s=r=1, so it never enters its x state.
- Tracks the expected flip-flop state so that redundant commands are suppressed.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from its stable level before the stable level flips. Legal range 1..(2**CNT_W - 1).
- CNT_W, 3: debounce counter width.
- SET_PRIORITY, 0: resolves simultaneous requests. 0 = clear wins, 1 = set wins.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- set_in  in  1  raw set request; asynchronous, may bounce.
- clr_in  in  1  raw clear request; asynchronous, may bounce.
- s  out  1  set pulse to the SR flip-flop; registered.
- r  out  1  reset pulse to the SR flip-flop; registered.
- q_exp  out  1  expected flip-flop q after the last issued command; registered.
- conflict  out  1  one-cycle pulse when set and clear requests are detected in the same cycle.
- ignored  out  1  one-cycle pulse when a request is dropped as redundant, or as the loser of a conflict.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge, all registers clear: sync flops, counters, stable levels, edge-detect delays, s=0, r=0, q_exp=0 (matches the flip-flop's power-up q=0), conflict=0, ignored=0.
- Per-input path: two-flop synchroniser, then debounce, then rising-edge detect. At each edge, with sync2 the second synchroniser flop:
  - If sync2==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sync2 and cnt<=0.
  - Else: cnt<=cnt+1.
- Request: req = stable & ~stable_d, where stable_d is stable delayed one cycle. Falling edges produce nothing.
- Glitch filtering: a bounce of fewer than DEBOUNCE_CYCLES consecutive differing sync2 cycles resets cnt and never flips stable.
- FSM: two states, Q_LOW and Q_HIGH; q_exp = (state==Q_HIGH). Each edge, with set_req/clr_req:
  - Neither: s=0, r=0, state holds.
  - set_req only: in Q_LOW, s<=1 and go to Q_HIGH. In Q_HIGH, ignored<=1 and no pulse.
  - clr_req only: in Q_HIGH, r<=1 and go to Q_LOW. In Q_LOW, ignored<=1 and no pulse.
  - Both: conflict<=1 and ignored<=1. The winner per SET_PRIORITY is then processed exactly as in the single-request cases. If the winner is also redundant, no pulse is issued.
- Pulse rules:
  - s, r, conflict and ignored are high for exactly one cycle per event.
  - s and r are never both 1 in any cycle; this is an invariant.
  - At most one command is issued per cycle.
- Latency: counting the first edge that samples set_in=1 as edge 1, s is high after edge DEBOUNCE_CYCLES+3 (edge 7 at default) and low again after the next edge.
- Held input: an input held high produces exactly one request. It must return low (debounced) before it can request again.
- Held through reset: an input high across rst deassertion produces a request after the normal latency, because stable resets to 0.
- Reset mid-operation: a pending count or in-flight pulse is discarded. The outputs are 0 in the cycle after the reset edge.

Decomposition:
- Shared package/header:
  - FSM state encodings Q_LOW=1'b0, Q_HIGH=1'b1.
  - Priority constants PRIO_CLR=0, PRIO_SET=1.
  - Default DEBOUNCE_CYCLES.
- Sub-module sr_debounce (parameters DEBOUNCE_CYCLES, CNT_W; ports clk, rst, din, stable, rise):
  - Contains synchroniser, counter, stable register and edge detect.
  - Instantiated twice.
- Top level holds only the FSM and output registers.

Test Plan:
- Clean set: rst 2 cycles; set_in=1 held 20 cycles -> s=1 only after edge 7, q_exp=1 thereafter, r=0 throughout, exactly one s pulse.
- Bounce rejection: set_in toggles 1,0,1,0 per cycle for 8 cycles then stays 0 -> no s pulse, q_exp stays 0. The same sequence ending held 1 -> exactly one s pulse, 7 edges after the final rise.
- Redundant command: after the clean set, pulse clr_in (held 10 cycles) -> one r pulse and q_exp=0. A second clr_in -> ignored=1 for one cycle, r stays 0.
- Simultaneous requests: set_in and clr_in rise on the same edge from Q_LOW.
  - SET_PRIORITY=1 -> s pulse, conflict=1, ignored=1, q_exp=1.
  - SET_PRIORITY=0 -> no pulse, conflict=1, ignored=1, q_exp=0.
- Reset mid-debounce: set_in high, rst=1 at edge 5 for 1 cycle -> all outputs 0. With set_in still held, s pulses 7 edges after rst deasserts.
- Invariant sweep: 5000 cycles of random set_in/clr_in -> s&r never 1. q_exp equals a reference SR flip-flop model driven by s and r.

Source files
------------

// File: rtl/sr_cmd_gen_pkg.sv
//------------------------------------------------------------------------------
// sr_cmd_gen_pkg : shared state encodings and constants for sr_cmd_gen
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sr_cmd_gen_pkg;

  typedef enum logic [0:0] {
    Q_LOW  = 1'b0,
    Q_HIGH = 1'b1
  } q_state_e;

  localparam int PRIO_CLR                = 0;
  localparam int PRIO_SET                = 1;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 3;

endpackage

`default_nettype wire

// File: rtl/sr_debounce.sv
//------------------------------------------------------------------------------
// sr_debounce : 2-flop synchroniser, counting debouncer and rising-edge detect
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_sync1    <= din;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Any sample matching the stable level restarts the run, so bounces never accumulate.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_stable & ~r_stable_d;

endmodule

`default_nettype wire

// File: rtl/sr_cmd_gen.sv
//------------------------------------------------------------------------------
// sr_cmd_gen : debounced set/clear requests to conflict-free SR pulses
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_cmd_gen
  import sr_cmd_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int SET_PRIORITY    = PRIO_CLR
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic q_exp,
  output logic conflict,
  output logic ignored
);

  logic     w_set_req;
  logic     w_clr_req;
  logic     w_set_stable_unused;
  logic     w_clr_stable_unused;
  logic     w_set_act;
  logic     w_clr_act;
  logic     w_s;
  logic     w_r;
  logic     w_conflict;
  logic     w_ignored;
  q_state_e w_next_state;

  q_state_e r_state;
  logic     r_s;
  logic     r_r;
  logic     r_conflict;
  logic     r_ignored;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_db (
    .clk    (clk),
    .rst    (rst),
    .din    (set_in),
    .stable (w_set_stable_unused),
    .rise   (w_set_req)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clr_db (
    .clk    (clk),
    .rst    (rst),
    .din    (clr_in),
    .stable (w_clr_stable_unused),
    .rise   (w_clr_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= Q_LOW;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      r_ignored  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_s        <= w_s;
      r_r        <= w_r;
      r_conflict <= w_conflict;
      r_ignored  <= w_ignored;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_s          = 1'b0;
    w_r          = 1'b0;
    w_conflict   = 1'b0;
    w_ignored    = 1'b0;
    w_set_act    = w_set_req;
    w_clr_act    = w_clr_req;

    // The loser is dropped here, so at most one of set/clear survives to issue a pulse.
    if (w_set_req && w_clr_req) begin
      w_conflict = 1'b1;
      w_ignored  = 1'b1;
      if (SET_PRIORITY == PRIO_SET) begin
        w_clr_act = 1'b0;
      end else begin
        w_set_act = 1'b0;
      end
    end

    if (w_set_act) begin
      if (r_state == Q_LOW) begin
        w_s          = 1'b1;
        w_next_state = Q_HIGH;
      end else begin
        w_ignored = 1'b1;
      end
    end

    if (w_clr_act) begin
      if (r_state == Q_HIGH) begin
        w_r          = 1'b1;
        w_next_state = Q_LOW;
      end else begin
        w_ignored = 1'b1;
      end
    end
  end

  assign s        = r_s;
  assign r        = r_r;
  assign q_exp    = (r_state == Q_HIGH);
  assign conflict = r_conflict;
  assign ignored  = r_ignored;

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
//------------------------------------------------------------------------------
// tb_sr_cmd_gen : directed self-checking bench, clear-priority and set-priority DUTs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst;
  logic set_in;
  logic clr_in;
  logic s0, r0, q0, c0, i0;
  logic s1, r1, q1, c1, i1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .SET_PRIORITY    (0)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .s        (s0),
    .r        (r0),
    .q_exp    (q0),
    .conflict (c0),
    .ignored  (i0)
  );

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .SET_PRIORITY    (1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .s        (s1),
    .r        (r1),
    .q_exp    (q1),
    .conflict (c1),
    .ignored  (i1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    logic qm0;
    logic qm1;
    int   hold;

    rst    = 1'b1;
    set_in = 1'b0;
    clr_in = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_s0", s0, 1'b0);
    chk("rst_r0", r0, 1'b0);
    chk("rst_q0", q0, 1'b0);
    chk("rst_c0", c0, 1'b0);
    chk("rst_i0", i0, 1'b0);
    chk("rst_q1", q1, 1'b0);

    // Clean set: first sampling edge is edge 1, pulse after edge 7
    rst    = 1'b0;
    set_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("clean_s0_k%0d", k), s0, (k == 7));
      chk($sformatf("clean_s1_k%0d", k), s1, (k == 7));
      chk($sformatf("clean_r0_k%0d", k), r0, 1'b0);
      chk($sformatf("clean_q0_k%0d", k), q0, (k >= 7));
      chk($sformatf("clean_i0_k%0d", k), i0, 1'b0);
    end
    set_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("fall_s0_k%0d", k), s0, 1'b0);
      chk($sformatf("fall_q0_k%0d", k), q0, 1'b1);
    end

    // Clear from Q_HIGH, then redundant clear
    clr_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("clr_r0_k%0d", k), r0, (k == 7));
      chk($sformatf("clr_s0_k%0d", k), s0, 1'b0);
      chk($sformatf("clr_i0_k%0d", k), i0, 1'b0);
      chk($sformatf("clr_q0_k%0d", k), q0, (k < 7));
    end
    clr_in = 1'b0;
    idle(10);
    clr_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("redund_i0_k%0d", k), i0, (k == 7));
      chk($sformatf("redund_i1_k%0d", k), i1, (k == 7));
      chk($sformatf("redund_r0_k%0d", k), r0, 1'b0);
      chk($sformatf("redund_c0_k%0d", k), c0, 1'b0);
      chk($sformatf("redund_q0_k%0d", k), q0, 1'b0);
    end
    clr_in = 1'b0;
    idle(10);

    // Bounce rejection, ending low
    for (int k = 0; k < 8; k++) begin
      set_in = (k % 2 == 0);
      step();
      chk($sformatf("bounce_s0_k%0d", k), s0, 1'b0);
    end
    set_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("bounce_tail_s0_k%0d", k), s0, 1'b0);
      chk($sformatf("bounce_tail_q0_k%0d", k), q0, 1'b0);
    end

    // Bounce then held high: one pulse 7 edges after the final rise
    for (int k = 0; k < 8; k++) begin
      set_in = (k % 2 == 0);
      step();
      chk($sformatf("bounce2_s0_k%0d", k), s0, 1'b0);
    end
    set_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("bounce_held_s0_k%0d", k), s0, (k == 7));
      chk($sformatf("bounce_held_q0_k%0d", k), q0, (k >= 7));
    end
    set_in = 1'b0;
    idle(10);
    clr_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("reclr_r0_k%0d", k), r0, (k == 7));
      chk($sformatf("reclr_r1_k%0d", k), r1, (k == 7));
    end
    clr_in = 1'b0;
    idle(10);

    // Simultaneous requests from Q_LOW
    set_in = 1'b1;
    clr_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("both_s0_k%0d", k), s0, 1'b0);
      chk($sformatf("both_r0_k%0d", k), r0, 1'b0);
      chk($sformatf("both_c0_k%0d", k), c0, (k == 7));
      chk($sformatf("both_i0_k%0d", k), i0, (k == 7));
      chk($sformatf("both_q0_k%0d", k), q0, 1'b0);
      chk($sformatf("both_s1_k%0d", k), s1, (k == 7));
      chk($sformatf("both_r1_k%0d", k), r1, 1'b0);
      chk($sformatf("both_c1_k%0d", k), c1, (k == 7));
      chk($sformatf("both_i1_k%0d", k), i1, (k == 7));
      chk($sformatf("both_q1_k%0d", k), q1, (k >= 7));
    end
    set_in = 1'b0;
    clr_in = 1'b0;
    idle(10);

    // Reset mid-debounce with set_in held
    set_in = 1'b1;
    idle(4);
    rst = 1'b1;
    step();
    chk("midrst_s0", s0, 1'b0);
    chk("midrst_r0", r0, 1'b0);
    chk("midrst_q0", q0, 1'b0);
    chk("midrst_c0", c0, 1'b0);
    chk("midrst_i0", i0, 1'b0);
    chk("midrst_q1", q1, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("postrst_s0_k%0d", k), s0, (k == 7));
      chk($sformatf("postrst_s1_k%0d", k), s1, (k == 7));
      chk($sformatf("postrst_q0_k%0d", k), q0, (k >= 7));
    end
    set_in = 1'b0;
    idle(10);

    // Random sweep against a reference SR flip-flop
    rst = 1'b1;
    step();
    step();
    rst  = 1'b0;
    qm0  = 1'b0;
    qm1  = 1'b0;
    hold = 0;
    for (int n = 0; n < 5000; n++) begin
      if (hold == 0) begin
        set_in = 1'($urandom_range(0, 1));
        clr_in = 1'($urandom_range(0, 1));
        hold   = int'($urandom_range(1, 12));
      end
      hold--;
      step();
      if (s0) qm0 = 1'b1;
      else if (r0) qm0 = 1'b0;
      if (s1) qm1 = 1'b1;
      else if (r1) qm1 = 1'b0;
      chk($sformatf("sweep_sr0_n%0d", n), s0 & r0, 1'b0);
      chk($sformatf("sweep_sr1_n%0d", n), s1 & r1, 1'b0);
      chk($sformatf("sweep_q0_n%0d", n), q0, qm0);
      chk($sformatf("sweep_q1_n%0d", n), q1, qm1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
